// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One operation at a time, fixed
// latency of XLEN+2 cycles from the accepting edge to the done pulse.
//
// Ports:
//   clk     - core clock, rising edge
//   rst     - synchronous active-high reset
//   start   - accept op_a/op_b/funct3/rd_in on this edge when idle
//   funct3  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//             100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a    - rs1 value (multiplicand / dividend)
//   op_b    - rs2 value (multiplier / divisor)
//   rd_in   - destination register index
//   busy    - high while an operation is in flight (stalls the core)
//   done    - one-cycle pulse, result/rd_out valid
//   wb_en   - register-write strobe, done qualified by rd_out != 0
//   result  - computed value, held until the next done
//   rd_out  - destination index, held with result
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            wb_en,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned CNT_W  = $clog2(XLEN);
  localparam int unsigned PROD_W = 2 * XLEN;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   opnd_q;     // multiplicand (mul) or divisor (div) magnitude
  logic [PROD_W-1:0] prod_q;     // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
  logic              neg_q;      // negate MULH* high half or quotient
  logic              rem_neg_q;  // remainder takes the dividend sign
  logic              div_zero_q;

  logic load_c, step_c, fix_c;
  logic busy_d, done_d, wb_en_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control decode; busy/done/wb_en are registered from these
  always_comb begin
    load_c  = 1'b0;
    step_c  = 1'b0;
    fix_c   = 1'b0;
    busy_d  = (state_d != S_IDLE);
    done_d  = 1'b0;
    wb_en_d = 1'b0;
    case (state_q)
      S_IDLE: load_c = start;
      S_CALC: step_c = 1'b1;
      S_FIX: begin
        fix_c   = 1'b1;
        done_d  = 1'b1;
        wb_en_d = (rd_q != 5'd0);
      end
      default: ;
    endcase
  end

  // Operand sign handling at accept time
  logic            a_signed_c, b_signed_c, a_neg_c, b_neg_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c;

  always_comb begin
    a_signed_c = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                 (funct3 == F_DIV)  || (funct3 == F_REM);
    b_signed_c = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    a_neg_c    = a_signed_c & op_a[XLEN-1];
    b_neg_c    = b_signed_c & op_b[XLEN-1];
    a_mag_c    = a_neg_c ? (~op_a + XLEN'(1)) : op_a;
    b_mag_c    = b_neg_c ? (~op_b + XLEN'(1)) : op_b;
  end

  // One iteration: shift-add multiply step and restoring divide step
  logic [XLEN:0]     mul_sum_c;
  logic [PROD_W-1:0] mul_next_c;
  logic [XLEN:0]     rem_shift_c, div_diff_c;
  logic              div_ge_c;
  logic [PROD_W-1:0] div_next_c;

  always_comb begin
    mul_sum_c   = {1'b0, prod_q[PROD_W-1:XLEN]} + {1'b0, opnd_q};
    mul_next_c  = prod_q[0] ? {mul_sum_c, prod_q[XLEN-1:1]}
                            : {1'b0, prod_q[PROD_W-1:1]};
    rem_shift_c = {prod_q[PROD_W-1:XLEN], prod_q[XLEN-1]};
    div_diff_c  = rem_shift_c - {1'b0, opnd_q};
    // No borrow means the shifted remainder covers the divisor
    div_ge_c    = ~div_diff_c[XLEN];
    div_next_c  = {(div_ge_c ? div_diff_c[XLEN-1:0] : rem_shift_c[XLEN-1:0]),
                   prod_q[XLEN-2:0], div_ge_c};
  end

  // Result selection with sign correction
  logic [XLEN-1:0] hi_c, lo_c, mulh_c, quot_c, rem_c, res_c;

  always_comb begin
    hi_c   = prod_q[PROD_W-1:XLEN];
    lo_c   = prod_q[XLEN-1:0];
    // Upper half of the negated 2*XLEN product: carry into it only when the low half is zero
    mulh_c = neg_q ? ((lo_c == '0) ? (~hi_c + XLEN'(1)) : ~hi_c) : hi_c;
    quot_c = div_zero_q ? '1 : (neg_q ? (~lo_c + XLEN'(1)) : lo_c);
    rem_c  = rem_neg_q ? (~hi_c + XLEN'(1)) : hi_c;
    case (funct3_q)
      F_MUL:                    res_c = lo_c;
      F_MULH, F_MULHSU, F_MULHU: res_c = mulh_c;
      F_DIV, F_DIVU:            res_c = quot_c;
      default:                  res_c = rem_c;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      wb_en      <= 1'b0;
      result     <= '0;
      rd_out     <= '0;
      cnt_q      <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      opnd_q     <= '0;
      prod_q     <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      busy  <= busy_d;
      done  <= done_d;
      wb_en <= wb_en_d;
      if (load_c) begin
        funct3_q <= funct3;
        rd_q     <= rd_in;
        cnt_q    <= '0;
        neg_q    <= a_neg_c ^ b_neg_c;
        if (funct3[2]) begin
          opnd_q     <= b_mag_c;
          prod_q     <= {XLEN'(0), a_mag_c};
          rem_neg_q  <= a_neg_c;
          div_zero_q <= (op_b == '0);
        end else begin
          opnd_q     <= a_mag_c;
          prod_q     <= {XLEN'(0), b_mag_c};
          rem_neg_q  <= 1'b0;
          div_zero_q <= 1'b0;
        end
      end
      if (step_c) begin
        prod_q <= funct3_q[2] ? div_next_c : mul_next_c;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      if (fix_c) begin
        result <= res_c;
        rd_out <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes reference results,
// a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;
  localparam int LAT = 34;  // accepting edge to the negedge where done is seen

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a, op_b;
  logic [4:0]      rd_in;
  logic            busy, done, wb_en;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .wb_en(wb_en),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wb;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model straight from the RV32M definitions using 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'b000: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'b011: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("rd_out", 64'(rd_out), 64'(e.rd));
        check("wb_en", 64'(wb_en), 64'(e.wb));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    exp_t e;
    wait_idle();
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    e.res = ref_model(f, a, b);
    e.rd  = rd;
    e.wb  = (rd != 5'd0);
    e.cyc = cyc + LAT;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_rise", 64'(busy), 64'(1));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_wb_en", 64'(wb_en), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_rd_out", 64'(rd_out), 64'(0));

    // Directed cases
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1);
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    do_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6);
    do_op(3'b101, 32'd20, 32'd0, 5'd7);
    do_op(3'b111, 32'd20, 32'd0, 5'd8);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd0, 5'd11);

    // A start while busy must be ignored; then an op to x0
    do_op(3'b100, 32'd100, 32'd7, 5'd12);
    repeat (4) @(negedge clk);
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_op(3'b000, 32'd9, 32'd9, 5'd0);

    // Reset in the middle of an operation aborts it
    do_op(3'b000, 32'd123, 32'd456, 5'd14);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    check("abort_rd_out", 64'(rd_out), 64'(0));
    repeat (40) @(negedge clk);
    do_op(3'b000, 32'd6, 32'd7, 5'd15);

    // Randomized operations
    for (int i = 0; i < 200; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
